// File: rtl/sap_cpu_param_if.sv
// Program-load side port plus output/debug signals of the SAP-class core.
// The bench or host drives the load side and observes the rest.
interface sap_cpu_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic [ADDR_W-1:0] pc_dbg;
  logic [1:0]        flags_dbg;

  modport master (
    output load_en, load_addr, load_data,
    input  out_data, out_valid, halted, pc_dbg, flags_dbg
  );

  modport slave (
    input  load_en, load_addr, load_data,
    output out_data, out_valid, halted, pc_dbg, flags_dbg
  );
endinterface

// File: rtl/sap_cpu_param.sv
// Parametrised SAP-class CPU: writable RAM, C/Z flags, conditional jumps,
// multi-cycle T-state sequencer executing one instruction at a time.
module sap_cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic            clk,
  input logic            rst,
  sap_cpu_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {T1, T2, T3, T4, T5, HALT} state_e;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h3,
    OP_LDI = 4'h4,
    OP_JMP = 4'h5,
    OP_JC  = 4'h6,
    OP_JZ  = 4'h7,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b;
  logic              c;
  logic              z;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;

  opcode_e           op;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] operand_ext;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;

  assign op          = opcode_e'(ir[DATA_W-1 -: 4]);
  assign operand     = ir[ADDR_W-1:0];
  assign operand_ext = {{(DATA_W - ADDR_W){1'b0}}, operand};
  assign mem_rd      = mem[mar];
  assign sum         = {1'b0, acc} + {1'b0, b};
  assign diff        = acc - b;

  // Loads are only honoured while the core is stopped; STA is dropped under rst.
  // NOTE: memory has no reset branch -- clearing a RAM array would force it into flops.
  always_ff @(posedge clk) begin
    if (bus.load_en && (rst || halted)) begin
      mem[bus.load_addr] <= bus.load_data;
    end else if (!rst && state == T4 && op == OP_STA) begin
      mem[mar] <= acc;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= T1;
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      acc       <= '0;
      b         <= '0;
      c         <= 1'b0;
      z         <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        T1: begin
          mar   <= pc;
          state <= T2;
        end
        T2: begin
          ir    <= mem_rd;
          pc    <= pc + ADDR_W'(1);
          state <= T3;
        end
        T3: begin
          state <= T1;
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar   <= operand;
              state <= T4;
            end
            OP_LDI: begin
              acc <= operand_ext;
              z   <= (operand_ext == '0);
            end
            OP_JMP: pc <= operand;
            OP_JC:  if (c) pc <= operand;
            OP_JZ:  if (z) pc <= operand;
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: ;
          endcase
        end
        T4: begin
          state <= T1;
          case (op)
            OP_LDA: begin
              acc <= mem_rd;
              z   <= (mem_rd == '0);
            end
            OP_ADD, OP_SUB: begin
              b     <= mem_rd;
              state <= T5;
            end
            default: ;
          endcase
        end
        T5: begin
          state <= T1;
          if (op == OP_ADD) begin
            {c, acc} <= sum;
            z        <= (sum[DATA_W-1:0] == '0);
          end else begin
            acc <= diff;
            c   <= (acc >= b);
            z   <= (diff == '0);
          end
        end
        HALT:    state <= HALT;
        default: state <= T1;
      endcase
    end
  end

  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.halted    = halted;
  assign bus.pc_dbg    = pc;
  assign bus.flags_dbg = {c, z};

endmodule

// File: tb/tb_sap_cpu_param.sv
// Directed self-checking bench for sap_cpu_param with hand-computed programs.
module tb_sap_cpu_param;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;

  sap_cpu_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sap_cpu_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int            run_cyc;
  int            first_out_cyc;
  bit            back2back;
  logic [DW-1:0] outs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requires rst=1; one write per cycle.
  task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    @(negedge clk);
    bus.load_en   = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] data);
    for (int i = 0; i < 2 ** AW; i++) load(AW'(i), data);
  endtask

  // Releases rst and runs until halted or the cycle budget expires.
  task automatic run(input int max_cyc, input int poke_at,
                     input logic [AW-1:0] poke_addr, input logic [DW-1:0] poke_data);
    bit prev_valid = 1'b0;
    run_cyc       = 0;
    first_out_cyc = -1;
    back2back     = 1'b0;
    outs.delete();
    rst = 1'b0;
    while (!bus.halted && run_cyc < max_cyc) begin
      if (run_cyc == poke_at) begin
        bus.load_en   = 1'b1;
        bus.load_addr = poke_addr;
        bus.load_data = poke_data;
      end
      @(negedge clk);
      run_cyc++;
      bus.load_en = 1'b0;
      if (bus.out_valid === 1'b1) begin
        outs.push_back(bus.out_data);
        if (first_out_cyc < 0) first_out_cyc = run_cyc;
        if (prev_valid) back2back = 1'b1;
      end
      prev_valid = (bus.out_valid === 1'b1);
    end
    check("halt_reached", 32'(bus.halted), 32'd1);
    check("no_back2back_valid", 32'(back2back), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] pc_trace [40];
    bit any_x;

    rst           = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", 32'(bus.pc_dbg), 32'd0);
    check("rst_flags", 32'(bus.flags_dbg), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);

    // 1: LDA 9, ADD 10, OUT, HLT ; 5+3
    fill(8'hF0);
    load(4'd0, 8'h09); load(4'd1, 8'h1A); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
    load(4'd9, 8'h05); load(4'd10, 8'h03);
    run(100, -1, '0, '0);
    check("t1_out_count", 32'(outs.size()), 32'd1);
    if (outs.size() > 0) check("t1_out_data", 32'(outs[0]), 32'h08);
    check("t1_out_cycle", 32'(first_out_cyc), 32'd12);
    check("t1_halt_cycle", 32'(run_cyc), 32'd15);
    check("t1_flags", 32'(bus.flags_dbg), 32'b00);
    check("t1_pc", 32'(bus.pc_dbg), 32'd4);

    // 2a: 3-5 borrows: 0xFE, C=0, JC not taken
    rst = 1'b1;
    fill(8'hF0);
    load(4'd0, 8'h08); load(4'd1, 8'h29); load(4'd2, 8'h67); load(4'd3, 8'hE0);
    load(4'd4, 8'hF0); load(4'd7, 8'hF0); load(4'd8, 8'h03); load(4'd9, 8'h05);
    run(100, -1, '0, '0);
    check("t2a_out_count", 32'(outs.size()), 32'd1);
    if (outs.size() > 0) check("t2a_out_data", 32'(outs[0]), 32'hFE);
    check("t2a_flags", 32'(bus.flags_dbg), 32'b00);
    check("t2a_pc", 32'(bus.pc_dbg), 32'd5);
    check("t2a_cycles", 32'(run_cyc), 32'd18);

    // 2b: 5-3 no borrow: C=1, JC taken to HLT at 7
    rst = 1'b1;
    @(negedge clk);
    load(4'd8, 8'h05); load(4'd9, 8'h03);
    run(100, -1, '0, '0);
    check("t2b_out_count", 32'(outs.size()), 32'd0);
    check("t2b_flags", 32'(bus.flags_dbg), 32'b10);
    check("t2b_pc", 32'(bus.pc_dbg), 32'd8);
    check("t2b_cycles", 32'(run_cyc), 32'd15);

    // 3: countdown LDI 3; loop {OUT; SUB 15; JZ 5; JMP 1}; 5: HLT
    rst = 1'b1;
    fill(8'hF0);
    load(4'd0, 8'h43); load(4'd1, 8'hE0); load(4'd2, 8'h2F); load(4'd3, 8'h75);
    load(4'd4, 8'h51); load(4'd5, 8'hF0); load(4'd15, 8'h01);
    run(200, -1, '0, '0);
    check("t3_out_count", 32'(outs.size()), 32'd3);
    if (outs.size() == 3) begin
      check("t3_out0", 32'(outs[0]), 32'd3);
      check("t3_out1", 32'(outs[1]), 32'd2);
      check("t3_out2", 32'(outs[2]), 32'd1);
    end
    check("t3_flags", 32'(bus.flags_dbg), 32'b11);
    check("t3_pc", 32'(bus.pc_dbg), 32'd6);
    check("t3_cycles", 32'(run_cyc), 32'd45);

    // 4: LDI 7, STA 12, LDA 12, OUT, LDA 13, OUT, HLT; load_en to 13 while running is ignored
    rst = 1'b1;
    fill(8'hF0);
    load(4'd0, 8'h47); load(4'd1, 8'h3C); load(4'd2, 8'h0C); load(4'd3, 8'hE0);
    load(4'd4, 8'h0D); load(4'd5, 8'hE0); load(4'd6, 8'hF0);
    load(4'd12, 8'h55); load(4'd13, 8'h21);
    run(100, 2, 4'd13, 8'h99);
    check("t4_out_count", 32'(outs.size()), 32'd2);
    if (outs.size() == 2) begin
      check("t4_sta_readback", 32'(outs[0]), 32'h07);
      check("t4_load_ignored", 32'(outs[1]), 32'h21);
    end

    // 4b: self-modify: LDA 10 (=HLT), STA 3 overwrites OUT, NOP, [HLT]
    rst = 1'b1;
    fill(8'hF0);
    load(4'd0, 8'h0A); load(4'd1, 8'h33); load(4'd2, 8'h80); load(4'd3, 8'hE0);
    load(4'd4, 8'hF0); load(4'd10, 8'hF0);
    run(100, -1, '0, '0);
    check("t4b_out_count", 32'(outs.size()), 32'd0);
    check("t4b_pc", 32'(bus.pc_dbg), 32'd4);
    check("t4b_cycles", 32'(run_cyc), 32'd14);

    // 5a: NOP fill, HLT at 1
    rst = 1'b1;
    fill(8'h80);
    load(4'd1, 8'hF0);
    run(100, -1, '0, '0);
    check("t5a_pc", 32'(bus.pc_dbg), 32'd2);
    check("t5a_cycles", 32'(run_cyc), 32'd6);

    // 5b: JMP 15 at 0, NOP at 15 -> PC wraps 15 -> 0 forever
    rst = 1'b1;
    fill(8'h80);
    load(4'd0, 8'h5F);
    rst   = 1'b0;
    any_x = 1'b0;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      pc_trace[i] = bus.pc_dbg;
      if ($isunknown(bus.pc_dbg)) any_x = 1'b1;
    end
    check("t5b_pc_after_fetch", 32'(pc_trace[2]), 32'd1);
    check("t5b_pc_after_jmp", 32'(pc_trace[3]), 32'd15);
    check("t5b_pc_wrapped", 32'(pc_trace[5]), 32'd0);
    check("t5b_pc_second_jmp", 32'(pc_trace[9]), 32'd15);
    check("t5b_no_x", 32'(any_x), 32'd0);
    check("t5b_not_halted", 32'(bus.halted), 32'd0);

    // 6: LDI 9, OUT, STA 12, HLT ; rst asserted so it lands on STA's T4 edge (edge 10)
    rst = 1'b1;
    fill(8'hF0);
    load(4'd0, 8'h49); load(4'd1, 8'hE0); load(4'd2, 8'h3C); load(4'd3, 8'hF0);
    load(4'd12, 8'h5A);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    check("t6_pre_rst_pc", 32'(bus.pc_dbg), 32'd3);
    check("t6_pre_rst_out", 32'(bus.out_data), 32'h09);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_pc", 32'(bus.pc_dbg), 32'd0);
    check("t6_rst_out_data", 32'(bus.out_data), 32'd0);
    check("t6_rst_flags", 32'(bus.flags_dbg), 32'd0);
    check("t6_rst_halted", 32'(bus.halted), 32'd0);
    // reload under rst: LDA 12, OUT, HLT exposes the word STA would have written
    load(4'd0, 8'h0C); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
    run(100, -1, '0, '0);
    check("t6_out_count", 32'(outs.size()), 32'd1);
    if (outs.size() > 0) check("t6_sta_dropped", 32'(outs[0]), 32'h5A);
    check("t6_cycles", 32'(run_cyc), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sap_cpu_param.md
Name: sap_cpu_param

Overview:
- Parametrised next-generation SAP-class CPU core: generic data/address width, writable internal RAM (replaces the fixed ROM), carry/zero flags, conditional jumps, store, load-immediate, halt, and a valid-qualified output port.
- Multi-cycle T-state sequencer, one instruction at a time.
- Sits where the fixed-width SAP-1 top sits.
- Program is loaded through a side port while the core is in reset or halted.

Parameters:
- DATA_W, 8, accumulator/B/memory word width; must be >= 4+ADDR_W.
- ADDR_W, 4, address width; memory depth = 2**ADDR_W words.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_W  program-load address.
- load_data  in  DATA_W  program-load data.
- out_data  out  DATA_W  output register (ACC copy on OUT).
- out_valid  out  1  one-cycle pulse when out_data updates.
- halted  out  1  high after HLT executes; held until rst.
- pc_dbg  out  ADDR_W  current PC.
- flags_dbg  out  2  {C,Z}.

Behaviour:
- Instruction word:
  - opcode = bits [DATA_W-1:DATA_W-4]; operand = bits [ADDR_W-1:0]; remaining bits ignored.
  - Opcodes: 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 LDI, 5 JMP, 6 JC, 7 JZ, E OUT, F HLT. Any other opcode is a 3-cycle NOP.
- Memory:
  - Reg array; asynchronous read; synchronous write.
  - Not cleared by rst.
  - load_en writes mem[load_addr] <= load_data only while rst=1 or halted=1; ignored while running.
- Reset (rst=1 at an edge):
  - PC, ACC, B, MAR, IR, C, Z, out_data all 0; out_valid=0; halted=0; state=T1.
  - rst overrides any in-flight CPU action, so an STA write in that cycle is dropped. A load_en write in the same cycle still occurs.
- Sequencer states:
  - T1: MAR <= PC.
  - T2: IR <= mem[MAR]; PC <= PC+1, wrapping 2**ADDR_W-1 -> 0.
  - T3:
    - LDA/ADD/SUB/STA: MAR <= operand; go to T4.
    - LDI: ACC <= zero-extended operand; Z updated; go to T1.
    - JMP: PC <= operand.
    - JC: PC <= operand if C=1.
    - JZ: PC <= operand if Z=1.
    - OUT: out_data <= ACC; out_valid=1 for the next cycle only.
    - NOP: no action.
    - JMP/JC/JZ/OUT/NOP go to T1.
    - HLT: halted <= 1; go to HALT.
  - T4:
    - LDA: ACC <= mem[MAR]; Z updated; go to T1.
    - STA: mem[MAR] <= ACC; go to T1.
    - ADD/SUB: B <= mem[MAR]; go to T5.
  - T5:
    - ADD: {C,ACC} <= ACC+B.
    - SUB: ACC <= ACC-B (mod 2**DATA_W), C <= (ACC >= B) (no-borrow).
    - Z <= (result == 0); go to T1.
  - HALT: absorbing state; only rst leaves it.
- Cycle counts:
  - 3: LDI, JMP, JC, JZ, OUT, NOP, HLT.
  - 4: LDA, STA.
  - 5: ADD, SUB.
- Flags:
  - C changes only on ADD/SUB.
  - Z changes only on LDA/LDI/ADD/SUB.
  - STA, OUT and jumps preserve both flags.
- Self-modifying code is permitted: STA to an address later fetched returns the new value.
- out_valid is never high in two consecutive cycles (OUT takes at least 3 cycles).

Test Plan:
1. Basic add: load mem[0..3] = LDA 9, ADD 10, OUT, HLT; mem[9]=0x05, mem[10]=0x03; release rst → out_valid pulses once with out_data=0x08 on the cycle after the 12th edge; halted=1 after the 15th edge; C=0, Z=0.
2. Subtract with borrow: LDA a (0x03), SUB b (0x05), JC 7, OUT, HLT → out_data=0xFE, C=0, Z=0, jump not taken; with a=0x05 and b=0x03 → C=1, jump taken, no out_valid.
3. Countdown loop: LDI 3, then loop {OUT; SUB one; JZ end; JMP loop} → out_data sequence 3, 2, 1, then halt; exactly 3 out_valid pulses.
4. STA / self-modify: LDI 7, STA 12, LDA 12, OUT → out_data=0x07; load_en pulsed while running leaves memory unchanged.
5. PC wrap: fill mem with NOP (0x80) except mem[1]=HLT → PC runs 0, 1 and halts; with mem[15]=NOP and mem[0] = JMP 15 loop, PC goes 15 → 0 with no X.
6. Reset mid-instruction: assert rst during T4 of an STA → target word unchanged, all registers 0; reloading with load_en while rst=1 succeeds.
